wb_unit: RTL and testbench
==========================

# wb_unit

Writeback stage of the in-order core, directly downstream of the load/store unit. Consumes the LSU's issued instruction and result. For a valid, non-excepting instruction it produces a registered register-file write and counts the retirement. For an excepting instruction it runs a trap handshake with the CSR unit, then issues a pipeline-wide flush and redirect.

## Interface
- `RETIRE_CNT_W`, default 64: width of the retired-instruction counter.
- `i_clk` in 1: core clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_instr` in `issued_instr_t`: instruction from the LSU. Fields used: `valid`, `pc`, `decode.rd`, `decode.rd_valid`, `except.valid`, `except.cause`, `except.tval`.
- `i_data` in `reg_data_t`: LSU result (load data or passed-through ALU data).
- `o_stall` out 1: back-pressure to the LSU; high whenever state ≠ RUN.
- `o_rd_we` out 1: register-file write enable.
- `o_rd_idx` out 5: destination register index.
- `o_rd_data` out `reg_data_t`: write data.
- `o_trap_req` out 1: trap request to the CSR unit; held until acknowledged.
- `o_trap_pc` out `reg_data_t`: PC of the faulting instruction (becomes mepc/sepc).
- `o_trap_cause` out `reg_data_t`: exception cause.
- `o_trap_tval` out `reg_data_t`: trap value.
- `i_trap_ack` in 1: CSR unit accepted the trap; `i_trap_vec` is valid this cycle.
- `i_trap_vec` in `reg_data_t`: handler target PC.
- `o_flush` out 1: one-cycle flush pulse to all upstream stages.
- `o_redirect_pc` out `reg_data_t`: fetch redirect target; valid when `o_flush` is high.
- `o_retired` out `RETIRE_CNT_W`: retired-instruction count (minstret source).

## Operation
- States: RUN, TRAP_REQ, FLUSH.
- In RUN, a valid instruction with `except.valid=0` is retired:
  - `o_rd_we=1` only if `rd_valid=1` and `rd≠0`.
  - `o_rd_idx=rd`, `o_rd_data=i_data`.
  - `o_retired` increments by 1.
- In RUN, a valid instruction with `except.valid=1`:
  - latch `pc`/`cause`/`tval` into the `o_trap_*` registers;
  - no register write, no retire increment;
  - next state TRAP_REQ.
- TRAP_REQ:
  - `o_trap_req=1` and the `o_trap_*` outputs stay stable until `i_trap_ack`.
  - Incoming `i_instr` is ignored, even if valid; the LSU is already masking in-flight instructions.
  - On `i_trap_ack`, latch `i_trap_vec` into `o_redirect_pc` and go to FLUSH.
- FLUSH:
  - `o_flush=1` for exactly one cycle; `i_instr` is ignored.
  - Next state RUN; `o_trap_req` is already 0 in this cycle.
- Invalid `i_instr` (`valid=0`) in RUN: no write, no count, state unchanged.
- `o_retired` wraps modulo 2^`RETIRE_CNT_W` with no saturation.
- Writes to x0 are always suppressed, including for loads; the counter still increments.

## Timing
- Reset (async assert, sync release), all outputs:
  - `o_rd_we=0`, `o_rd_idx=0`, `o_rd_data=0`;
  - `o_trap_req=0`, `o_trap_pc`/`o_trap_cause`/`o_trap_tval=0`;
  - `o_flush=0`, `o_redirect_pc=0`, `o_retired=0`;
  - state RUN, so `o_stall=0`.
- All outputs are registered except `o_stall`, which is decoded from the state register.
- Retire latency is 1 cycle: instruction sampled at edge N gives `o_rd_we`/`o_retired` update visible after edge N.
- `o_rd_we` is a one-cycle pulse per retired instruction; with back-to-back valid instructions it stays high continuously.
- Trap path with `i_trap_ack` high in the first TRAP_REQ cycle:
  - faulting instruction at edge N;
  - `o_trap_req` high after N;
  - ack sampled at N+1;
  - `o_flush` high after N+1 for one cycle;
  - back in RUN after N+2.
  - Minimum trap-to-flush is therefore 2 cycles; it is unbounded if the ack is delayed.
- `i_trap_ack` sampled outside TRAP_REQ is ignored.
- Reset asserted mid-trap (TRAP_REQ or FLUSH) returns to RUN immediately with all outputs at reset values; no flush is emitted.

## Test plan
- Retire:
  - Stimulus: valid instruction, `rd=5`, `rd_valid=1`, `i_data=0xDEADBEEF`, no exception.
  - Required: next cycle `o_rd_we=1`, `o_rd_idx=5`, `o_rd_data=0xDEADBEEF`, `o_retired` 0→1.
- x0 suppression:
  - Stimulus: valid instruction, `rd=0`, `rd_valid=1`, `i_data=0x1234`.
  - Required: `o_rd_we=0`, `o_retired` increments.
- Trap with delayed ack:
  - Stimulus: valid instruction, `except.valid=1`, `pc=0x80001000`, `cause=13` (load page fault), `tval=0x4000`; hold `i_trap_ack` low 3 cycles, then pulse it with `i_trap_vec=0x80000100`.
  - Required: `o_trap_req` high 4 cycles with stable `o_trap_*` values; `o_stall` high throughout; `o_flush` high exactly 1 cycle with `o_redirect_pc=0x80000100`; no register write; `o_retired` unchanged.
- Instructions during trap:
  - Stimulus: valid non-excepting instructions during TRAP_REQ and FLUSH.
  - Required: no `o_rd_we`, no count.
- Counter wrap:
  - Stimulus: `RETIRE_CNT_W=4`, retire 17 instructions.
  - Required: `o_retired=1`.
- Async reset mid-trap:
  - Stimulus: assert `i_rst_n=0` between clock edges while in TRAP_REQ.
  - Required: `o_trap_req` and `o_stall` drop immediately, without waiting for a clock edge; after release, a normal retire works.

Source files
------------

// File: rtl/wb_unit.sv
// Writeback stage: registers RF writes and counts retirements. On an excepting
// instruction it runs a trap handshake with the CSR unit, then flushes and redirects fetch.
package wb_pkg;
  typedef logic [31:0] reg_data_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_valid;
  } decode_t;

  typedef struct packed {
    logic      valid;
    reg_data_t cause;
    reg_data_t tval;
  } except_t;

  typedef struct packed {
    logic      valid;
    reg_data_t pc;
    decode_t   decode;
    except_t   except;
  } issued_instr_t;
endpackage

module wb_unit
  import wb_pkg::*;
#(
  parameter int RETIRE_CNT_W = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  issued_instr_t           i_instr,
  input  reg_data_t               i_data,
  output logic                    o_stall,
  output logic                    o_rd_we,
  output logic [4:0]              o_rd_idx,
  output reg_data_t               o_rd_data,
  output logic                    o_trap_req,
  output reg_data_t               o_trap_pc,
  output reg_data_t               o_trap_cause,
  output reg_data_t               o_trap_tval,
  input  logic                    i_trap_ack,
  input  reg_data_t               i_trap_vec,
  output logic                    o_flush,
  output reg_data_t               o_redirect_pc,
  output logic [RETIRE_CNT_W-1:0] o_retired
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    TRAP_REQ = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic retire;
  logic take_trap;
  logic trap_done;

  always_comb begin
    retire    = 1'b0;
    take_trap = 1'b0;
    trap_done = 1'b0;
    state_d   = state_q;
    case (state_q)
      RUN: begin
        if (i_instr.valid) begin
          if (i_instr.except.valid) begin
            take_trap = 1'b1;
            state_d   = TRAP_REQ;
          end else begin
            retire = 1'b1;
          end
        end
      end
      TRAP_REQ: begin
        if (i_trap_ack) begin
          trap_done = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  assign o_stall = (state_q != RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_we       <= 1'b0;
      o_rd_idx      <= '0;
      o_rd_data     <= '0;
      o_trap_req    <= 1'b0;
      o_trap_pc     <= '0;
      o_trap_cause  <= '0;
      o_trap_tval   <= '0;
      o_flush       <= 1'b0;
      o_redirect_pc <= '0;
      o_retired     <= '0;
    end else begin
      o_rd_we <= 1'b0;
      o_flush <= 1'b0;
      if (retire) begin
        // x0 is hardwired; the instruction still counts as retired
        o_rd_we   <= i_instr.decode.rd_valid && (i_instr.decode.rd != 5'd0);
        o_rd_idx  <= i_instr.decode.rd;
        o_rd_data <= i_data;
        o_retired <= o_retired + 1'b1;
      end
      if (take_trap) begin
        o_trap_req   <= 1'b1;
        o_trap_pc    <= i_instr.pc;
        o_trap_cause <= i_instr.except.cause;
        o_trap_tval  <= i_instr.except.tval;
      end
      if (trap_done) begin
        o_trap_req    <= 1'b0;
        o_redirect_pc <= i_trap_vec;
        o_flush       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: stimulus queues expected writes/traps/flushes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_unit;
  import wb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  issued_instr_t instr;
  reg_data_t     data;
  logic          trap_ack;
  reg_data_t     trap_vec;

  logic        stall, rd_we, trap_req, flush;
  logic [4:0]  rd_idx;
  reg_data_t   rd_data, trap_pc, trap_cause, trap_tval, redirect_pc;
  logic [63:0] retired;

  logic        stall4, rd_we4, trap_req4, flush4;
  logic [4:0]  rd_idx4;
  reg_data_t   rd_data4, trap_pc4, trap_cause4, trap_tval4, redirect_pc4;
  logic [3:0]  retired4;

  wb_unit #(.RETIRE_CNT_W(64)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_data(data),
    .o_stall(stall), .o_rd_we(rd_we), .o_rd_idx(rd_idx), .o_rd_data(rd_data),
    .o_trap_req(trap_req), .o_trap_pc(trap_pc), .o_trap_cause(trap_cause),
    .o_trap_tval(trap_tval), .i_trap_ack(trap_ack), .i_trap_vec(trap_vec),
    .o_flush(flush), .o_redirect_pc(redirect_pc), .o_retired(retired)
  );

  wb_unit #(.RETIRE_CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_data(data),
    .o_stall(stall4), .o_rd_we(rd_we4), .o_rd_idx(rd_idx4), .o_rd_data(rd_data4),
    .o_trap_req(trap_req4), .o_trap_pc(trap_pc4), .o_trap_cause(trap_cause4),
    .o_trap_tval(trap_tval4), .i_trap_ack(trap_ack), .i_trap_vec(trap_vec),
    .o_flush(flush4), .o_redirect_pc(redirect_pc4), .o_retired(retired4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] idx; reg_data_t dat; } wr_exp_t;
  typedef struct { reg_data_t pc; reg_data_t cause; reg_data_t tval; int cycles; } trap_exp_t;

  wr_exp_t   wr_q[$];
  trap_exp_t trap_q[$];
  reg_data_t flush_q[$];

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic [4:0] rd, input logic rdv, input reg_data_t d);
    instr = '0;
    instr.valid = 1'b1;
    instr.pc = 32'h8000_0000;
    instr.decode.rd = rd;
    instr.decode.rd_valid = rdv;
    data = d;
  endtask

  task automatic set_fault(input reg_data_t pc, input reg_data_t cause, input reg_data_t tval);
    instr = '0;
    instr.valid = 1'b1;
    instr.pc = pc;
    instr.decode.rd = 5'd3;
    instr.decode.rd_valid = 1'b1;
    instr.except.valid = 1'b1;
    instr.except.cause = cause;
    instr.except.tval = tval;
    data = 32'hBAD0_BAD0;
  endtask

  // A reset cancels any trap in flight: no flush will follow it
  always @(negedge rst_n) begin
    trap_q.delete();
    req_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_rd_we", {59'd0, rd_idx}, 64'd0);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("rd_idx", {59'd0, rd_idx}, {59'd0, e.idx});
          chk("rd_data", {32'd0, rd_data}, {32'd0, e.dat});
        end
      end
      if (trap_req) begin
        req_cnt++;
        chk("stall_in_trap", {63'd0, stall}, 64'd1);
        if (trap_q.size() == 0) begin
          chk("unexpected_trap_req", 64'd1, 64'd0);
        end else begin
          chk("trap_pc", {32'd0, trap_pc}, {32'd0, trap_q[0].pc});
          chk("trap_cause", {32'd0, trap_cause}, {32'd0, trap_q[0].cause});
          chk("trap_tval", {32'd0, trap_tval}, {32'd0, trap_q[0].tval});
        end
      end
      if (flush) begin
        chk("stall_in_flush", {63'd0, stall}, 64'd1);
        if (flush_q.size() == 0 || trap_q.size() == 0) begin
          chk("unexpected_flush", {32'd0, redirect_pc}, 64'd0);
        end else begin
          reg_data_t v;
          trap_exp_t t;
          v = flush_q.pop_front();
          t = trap_q.pop_front();
          chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, v});
          chk("trap_req_cycles", 64'(req_cnt), 64'(t.cycles));
        end
        req_cnt = 0;
      end
    end
  end

  initial begin
    instr = '0;
    data = '0;
    trap_ack = 1'b0;
    trap_vec = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rd_we", {63'd0, rd_we}, 64'd0);
    chk("rst_rd_idx", {59'd0, rd_idx}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_trap_req", {63'd0, trap_req}, 64'd0);
    chk("rst_trap_pc", {32'd0, trap_pc}, 64'd0);
    chk("rst_trap_cause", {32'd0, trap_cause}, 64'd0);
    chk("rst_trap_tval", {32'd0, trap_tval}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect", {32'd0, redirect_pc}, 64'd0);
    chk("rst_retired", retired, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    rst_n = 1'b1;
    tick();

    // retire to r5
    set_retire(5'd5, 1'b1, 32'hDEAD_BEEF);
    wr_q.push_back('{idx: 5'd5, dat: 32'hDEAD_BEEF});
    tick();
    chk("retire_count1", retired, 64'd1);
    chk("retire_we", {63'd0, rd_we}, 64'd1);

    // write to x0 suppressed but counted
    set_retire(5'd0, 1'b1, 32'h0000_1234);
    tick();
    chk("x0_count", retired, 64'd2);
    chk("x0_we", {63'd0, rd_we}, 64'd0);

    // rd_valid=0 still retires without a write
    set_retire(5'd8, 1'b0, 32'h5555_5555);
    tick();
    chk("nord_count", retired, 64'd3);

    // idle cycle with stray ack: ignored outside TRAP_REQ
    instr = '0;
    trap_ack = 1'b1;
    trap_vec = 32'h1111_1111;
    tick();
    trap_ack = 1'b0;
    chk("idle_count", retired, 64'd3);
    chk("stray_ack_stall", {63'd0, stall}, 64'd0);
    chk("stray_ack_flush", {63'd0, flush}, 64'd0);

    // trap with 3 cycles of delayed ack; valid instrs keep arriving
    set_fault(32'h8000_1000, 32'd13, 32'h0000_4000);
    trap_q.push_back('{pc: 32'h8000_1000, cause: 32'd13, tval: 32'h0000_4000, cycles: 4});
    flush_q.push_back(32'h8000_0100);
    tick();
    chk("trap_req_rise", {63'd0, trap_req}, 64'd1);
    chk("trap_stall", {63'd0, stall}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      set_retire(5'd7, 1'b1, 32'h7777_0000 + i);
      tick();
      chk("trap_hold_req", {63'd0, trap_req}, 64'd1);
    end
    trap_ack = 1'b1;
    trap_vec = 32'h8000_0100;
    tick();
    trap_ack = 1'b0;
    trap_vec = 32'hFFFF_FFFF;
    chk("flush_pulse", {63'd0, flush}, 64'd1);
    chk("flush_req_low", {63'd0, trap_req}, 64'd0);
    set_retire(5'd9, 1'b1, 32'h9999_9999);
    tick();
    chk("flush_one_cycle", {63'd0, flush}, 64'd0);
    chk("back_in_run", {63'd0, stall}, 64'd0);
    chk("trap_no_count", retired, 64'd3);
    chk("trap_no_we", {63'd0, rd_we}, 64'd0);

    // async reset while in TRAP_REQ
    set_fault(32'h8000_2000, 32'd5, 32'h0000_0010);
    trap_q.push_back('{pc: 32'h8000_2000, cause: 32'd5, tval: 32'h0000_0010, cycles: 0});
    tick();
    chk("trap2_req", {63'd0, trap_req}, 64'd1);
    instr = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_trap_req", {63'd0, trap_req}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_retired", retired, 64'd0);
    chk("arst_trap_pc", {32'd0, trap_pc}, 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_flush", {63'd0, flush}, 64'd0);

    // normal retire after reset, then 16 more for the 4-bit wrap
    set_retire(5'd9, 1'b1, 32'h0000_A5A5);
    wr_q.push_back('{idx: 5'd9, dat: 32'h0000_A5A5});
    tick();
    chk("post_rst_count", retired, 64'd1);
    for (int i = 1; i <= 16; i++) begin
      set_retire(5'(i), 1'b1, 32'hC000_0000 + i);
      wr_q.push_back('{idx: 5'(i), dat: 32'hC000_0000 + i});
      tick();
    end
    chk("wrap_w4", {60'd0, retired4}, 64'd1);
    chk("wrap_w64", retired, 64'd17);
    chk("wrap_we_b2b", {63'd0, rd_we}, 64'd1);

    instr = '0;
    tick();
    tick();
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("trap_q_drained", 64'(trap_q.size()), 64'd0);
    chk("flush_q_drained", 64'(flush_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
